seq_serial_addsub: RTL and testbench

- Parametrised bit-serial adder/subtractor; successor to the fixed 4-bit sequential adder.
- Accepts two WIDTH-bit operands and a mode bit through a valid/ready handshake.
- Computes one bit per clock, LSB first, through a single full adder.
- Presents sum, carry and signed overflow through a second valid/ready handshake. Used where area matters more than latency.

---
 rtl/seq_adder_pkg.sv | 19 +
 rtl/full_adder.sv | 17 +
 rtl/seq_serial_addsub.sv | 138 +++++++++++++
 tb/tb_seq_serial_addsub.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_adder_pkg : shared FSM state type and sizing helper for the       |
// |                 bit-serial adder/subtractor.            Revision 1.0 |
// +----------------------------------------------------------------------+
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | full_adder : single-bit full adder.                     Revision 1.0 |
// +----------------------------------------------------------------------+
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/seq_serial_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_serial_addsub : bit-serial LSB-first adder/subtractor with       |
// |                     valid/ready in and out.         Revision 1.0     |
// +----------------------------------------------------------------------+
module seq_serial_addsub
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("seq_serial_addsub: WIDTH must be >= 2");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-2:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;

  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-1:0]   sum_shift;

  full_adder u_full_adder (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the word is aligned.
  assign sum_shift = {fa_s, acc_q};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (src_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = sum_shift[WIDTH-1:1];
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // carry_q is the carry into the MSB on this last step
          sum_d       = sum_shift;
          carry_out_d = fa_cout;
          overflow_d  = carry_q ^ fa_cout;
          cnt_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (dst_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign src_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign dst_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_serial_addsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_serial_addsub : directed bench for 8-bit instance plus an      |
// |                        exhaustive 4-bit sweep.        Revision 1.0   |
// +----------------------------------------------------------------------+
module tb_seq_serial_addsub;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  logic       src_valid8 = 1'b0, dst_ready8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       src_ready8, dst_valid8, carry8, ovf8, busy8;

  logic       src_valid4 = 1'b0, dst_ready4 = 1'b1, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       src_ready4, dst_valid4, carry4, ovf4, busy4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .src_valid(src_valid8), .src_ready(src_ready8),
    .a(a8), .b(b8), .sub(sub8), .dst_valid(dst_valid8), .dst_ready(dst_ready8),
    .sum(sum8), .carry_out(carry8), .overflow(ovf8), .busy(busy8)
  );

  seq_serial_addsub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .src_valid(src_valid4), .src_ready(src_ready4),
    .a(a4), .b(b4), .sub(sub4), .dst_valid(dst_valid4), .dst_ready(dst_ready4),
    .sum(sum4), .carry_out(carry4), .overflow(ovf4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for dst_valid8 after an accept edge; reports cycles taken and busy history.
  task automatic wait_dv8(output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      busy_ok = busy_ok & busy8;
    end while (!dst_valid8 && lat < 30);
  endtask

  task automatic release8();
    dst_ready8 = 1'b1;
    @(posedge clk); #1;
    dst_ready8 = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic ts, input logic [7:0] es, input logic ec, input logic ev);
    int   lat;
    logic bok;
    a8 = ta; b8 = tb; sub8 = ts; src_valid8 = 1'b1;
    @(posedge clk); #1;
    src_valid8 = 1'b0;
    wait_dv8(lat, bok);
    check({tag, "_lat"},   32'(lat), 32'd8);
    check({tag, "_busy"},  32'(bok), 32'd1);
    check({tag, "_sum"},   32'(sum8), 32'(es));
    check({tag, "_carry"}, 32'(carry8), 32'(ec));
    check({tag, "_ovf"},   32'(ovf8), 32'(ev));
    release8();
    check({tag, "_rdy"},   32'(src_ready8), 32'd1);
  endtask

  initial begin
    int   lat;
    logic bok;
    int   n;
    int   last_cyc;
    int   ca, cb, cs, sa, sb, r, u;

    // Reset held: handshake attempts must not take effect.
    a8 = 8'h12; b8 = 8'h34; src_valid8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy8), 32'd0);
    check("rst_rdy",   32'(src_ready8), 32'd1);
    check("rst_dv",    32'(dst_valid8), 32'd0);
    check("rst_sum",   32'(sum8), 32'd0);
    check("rst_carry", 32'(carry8), 32'd0);
    check("rst_ovf",   32'(ovf8), 32'd0);
    src_valid8 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    do_op("add100_27", 8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0);
    do_op("add127_1",  8'd127, 8'd1,  1'b0, 8'h80,  1'b0, 1'b1);
    do_op("addFF_01",  8'hFF,  8'h01, 1'b0, 8'h00,  1'b1, 1'b0);
    do_op("sub5_7",    8'd5,   8'd7,  1'b1, 8'hFE,  1'b0, 1'b0);
    do_op("sub80_01",  8'h80,  8'h01, 1'b1, 8'h7F,  1'b1, 1'b1);

    // Backpressure with competing operands offered while DONE.
    a8 = 8'd50; b8 = 8'd60; sub8 = 1'b0; src_valid8 = 1'b1;
    @(posedge clk); #1;
    src_valid8 = 1'b0;
    wait_dv8(lat, bok);
    check("bp_lat", 32'(lat), 32'd8);
    check("bp_sum", 32'(sum8), 32'd110);
    a8 = 8'd1; b8 = 8'd1; src_valid8 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_hold_sum", 32'(sum8), 32'd110);
      check("bp_hold_dv",  32'(dst_valid8), 32'd1);
      check("bp_hold_rdy", 32'(src_ready8), 32'd0);
    end
    dst_ready8 = 1'b1;
    @(posedge clk); #1;
    dst_ready8 = 1'b0;
    check("bp_rdy_after", 32'(src_ready8), 32'd1);
    check("bp_sum_kept",  32'(sum8), 32'd110);
    @(posedge clk); #1;
    src_valid8 = 1'b0;
    wait_dv8(lat, bok);
    check("bp_next_lat", 32'(lat), 32'd8);
    check("bp_next_sum", 32'(sum8), 32'd2);
    release8();

    // Asynchronous reset in the third CALC cycle.
    a8 = 8'h33; b8 = 8'h44; sub8 = 1'b0; src_valid8 = 1'b1;
    @(posedge clk); #1;
    src_valid8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    check("abort_sum",  32'(sum8), 32'd0);
    check("abort_carry", 32'(carry8), 32'd0);
    check("abort_ovf",  32'(ovf8), 32'd0);
    check("abort_dv",   32'(dst_valid8), 32'd0);
    check("abort_busy", 32'(busy8), 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    do_op("add10_20", 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0);

    // Exhaustive WIDTH=4 sweep, back-to-back with dst_ready tied high.
    last_cyc = -1;
    {sub4, a4, b4} = 9'd0;
    src_valid4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      n = 0;
      while (!src_ready4 && n < 10) begin @(posedge clk); #1; n++; end
      check("w4_rdy", 32'(src_ready4), 32'd1);
      ca = int'(a4); cb = int'(b4); cs = int'(sub4);
      @(posedge clk); #1;
      if (i < 511) {sub4, a4, b4} = 9'(i + 1);
      else src_valid4 = 1'b0;
      n = 0;
      while (!dst_valid4 && n < 20) begin @(posedge clk); #1; n++; end
      check("w4_dv", 32'(dst_valid4), 32'd1);
      if (last_cyc >= 0) check("w4_spacing", 32'(cyc - last_cyc), 32'd6);
      last_cyc = cyc;
      sa = (ca >= 8) ? ca - 16 : ca;
      sb = (cb >= 8) ? cb - 16 : cb;
      r  = (cs != 0) ? sa - sb : sa + sb;
      u  = (cs != 0) ? ca - cb : ca + cb;
      check("w4_sum",   32'(sum4), 32'(u & 15));
      check("w4_carry", 32'(carry4), (cs != 0) ? 32'(ca >= cb) : 32'(ca + cb > 15));
      check("w4_ovf",   32'(ovf4), 32'((r < -8) || (r > 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
